// File: rtl/pmu_pkg.sv
// pmu_pkg: shared PMU power-state encodings and request-controller FSM states
package pmu_pkg;
    typedef enum logic [1:0] {
        PS_ACTIVE = 2'b00,
        PS_SLEEP  = 2'b01,
        PS_DEEP   = 2'b10,
        PS_WAKING = 2'b11
    } power_state_e;
    typedef enum logic [2:0] {
        ST_ACT, ST_REQ_SLP, ST_SLP, ST_REQ_DEEP, ST_DEEP, ST_REQ_WAKE
    } prc_state_e;
    function automatic prc_state_e ps_to_state(power_state_e ps);
        return ps == PS_ACTIVE ? ST_ACT : ps == PS_SLEEP ? ST_SLP : ps == PS_DEEP ? ST_DEEP : ST_REQ_WAKE;
    endfunction
    function automatic power_state_e state_to_ps(prc_state_e st);
        return st == ST_SLP ? PS_SLEEP : st == ST_DEEP ? PS_DEEP : PS_ACTIVE;
    endfunction
endpackage

// File: rtl/power_request_controller_activity_detect.sv
// activity_detect: registered pad-toggle / external-wake activity flag
module activity_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             ext_wake,
    output logic             activity
);
    logic [WIDTH-1:0] a_q;
    logic             act_d, act_q;
    always_comb act_d = |(a ^ a_q) | ext_wake;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            act_q <= 1'b0;
        end else begin
            a_q   <= a;
            act_q <= act_d;
        end
    end
    assign activity = act_q;
endmodule

// File: rtl/power_request_controller.sv
// power_request_controller: idle/activity monitor driving PMU sleep, deep-sleep and wake requests
module power_request_controller
    import pmu_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int CNT_W             = 16,
    parameter int IDLE_SLEEP_CYCLES = 64,
    parameter int IDLE_DEEP_CYCLES  = 256,
    parameter int ACK_TIMEOUT       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic             ext_wake,
    input  logic             force_sleep,
    input  logic [1:0]       power_state,
    input  logic             err_clr,
    output logic             sleep_req,
    output logic             deep_sleep_req,
    output logic             wakeup_req,
    output logic             req_err,
    output logic [CNT_W-1:0] idle_cnt
);
    localparam logic [CNT_W-1:0] SLP_LAST  = CNT_W'(IDLE_SLEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEEP_LAST = CNT_W'(IDLE_DEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    prc_state_e       state_d, state_q;
    power_state_e     ps;
    logic [CNT_W-1:0] idle_cnt_d, idle_cnt_q, ack_cnt_d, ack_cnt_q, idle_inc, ack_inc;
    logic             wake_pend_d, wake_pend_q, req_err_d, req_err_q, err_set, activity;
    logic             sleep_req_d, sleep_req_q, deep_sleep_req_d, deep_sleep_req_q;
    logic             wakeup_req_d, wakeup_req_q;

    activity_detect #(.WIDTH(WIDTH)) u_act (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (A),
        .ext_wake (ext_wake),
        .activity (activity)
    );

    assign ps = power_state_e'(power_state);

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = '0;
        ack_cnt_d   = '0;
        wake_pend_d = 1'b0;
        err_set     = 1'b0;
        idle_inc    = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
        ack_inc     = (ack_cnt_q == '1) ? ack_cnt_q : ack_cnt_q + CNT_W'(1);
        case (state_q)
            ST_ACT, ST_SLP, ST_DEEP: begin
                if (!enable) state_d = state_q;
                else if (ps != state_to_ps(state_q)) state_d = ps_to_state(ps);
                else if (state_q == ST_ACT) begin
                    if (force_sleep || (!activity && idle_cnt_q == SLP_LAST)) state_d = ST_REQ_SLP;
                    else if (!activity) idle_cnt_d = idle_inc;
                end
                else if (activity) state_d = ST_REQ_WAKE;
                else if (state_q == ST_SLP) begin
                    if (idle_cnt_q == DEEP_LAST) state_d = ST_REQ_DEEP;
                    else idle_cnt_d = idle_inc;
                end
            end
            ST_REQ_SLP, ST_REQ_DEEP: begin
                if (ps == (state_q == ST_REQ_SLP ? PS_SLEEP : PS_DEEP))
                    state_d = (wake_pend_q || activity) ? ST_REQ_WAKE : (state_q == ST_REQ_SLP ? ST_SLP : ST_DEEP);
                else if (ack_cnt_q == ACK_LAST) begin
                    err_set = 1'b1;
                    state_d = (state_q == ST_REQ_SLP) ? ST_ACT : ST_SLP;
                end else begin
                    ack_cnt_d   = ack_inc;
                    wake_pend_d = wake_pend_q | activity;
                end
            end
            ST_REQ_WAKE: begin
                // WAKING is progress: hold the timeout count while the PMU ramps up
                if (ps == PS_ACTIVE) state_d = ST_ACT;
                else if (ps == PS_WAKING) ack_cnt_d = ack_cnt_q;
                else if (ack_cnt_q == ACK_LAST) err_set = 1'b1;
                else ack_cnt_d = ack_inc;
            end
            default: state_d = ST_ACT;
        endcase
        req_err_d        = err_set | (req_err_q & ~err_clr);
        sleep_req_d      = state_d == ST_REQ_SLP;
        deep_sleep_req_d = state_d == ST_REQ_DEEP;
        wakeup_req_d     = state_d == ST_REQ_WAKE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_ACT;
            idle_cnt_q       <= '0;
            ack_cnt_q        <= '0;
            wake_pend_q      <= 1'b0;
            req_err_q        <= 1'b0;
            sleep_req_q      <= 1'b0;
            deep_sleep_req_q <= 1'b0;
            wakeup_req_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            idle_cnt_q       <= idle_cnt_d;
            ack_cnt_q        <= ack_cnt_d;
            wake_pend_q      <= wake_pend_d;
            req_err_q        <= req_err_d;
            sleep_req_q      <= sleep_req_d;
            deep_sleep_req_q <= deep_sleep_req_d;
            wakeup_req_q     <= wakeup_req_d;
        end
    end

    assign sleep_req      = sleep_req_q;
    assign deep_sleep_req = deep_sleep_req_q;
    assign wakeup_req     = wakeup_req_q;
    assign req_err        = req_err_q;
    assign idle_cnt       = idle_cnt_q;
endmodule

// File: tb/tb_power_request_controller.sv
// tb_power_request_controller: directed, table-driven and randomized checks of the PMU request controller
module tb_power_request_controller;
    import pmu_pkg::*;
    localparam int IS = 64, ID = 256, AT = 32;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1, ext_wake = 1'b0, force_sleep = 1'b0, err_clr = 1'b0;
    logic [3:0]  a = 4'h0;
    logic [1:0]  power_state = 2'd0;
    logic        sleep_req, deep_sleep_req, wakeup_req, req_err;
    logic [15:0] idle_cnt;
    int          total = 0, bad = 0;

    // reference: m_req is the PMU state currently requested (0 none, 1 sleep, 2 deep, 3 wake),
    // m_mode the PMU state being monitored when no request is outstanding
    int          m_req, m_mode, m_idle, m_wait;
    bit          m_pend, m_err, m_act;
    logic [3:0]  m_a;

    typedef struct {
        logic       en, frc, ext, clr;
        logic [3:0] av;
        logic [1:0] ps;
        logic [3:0] want;
    } vec_t;
    vec_t tbl[17];

    power_request_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .A              (a),
        .ext_wake       (ext_wake),
        .force_sleep    (force_sleep),
        .power_state    (power_state),
        .err_clr        (err_clr),
        .sleep_req      (sleep_req),
        .deep_sleep_req (deep_sleep_req),
        .wakeup_req     (wakeup_req),
        .req_err        (req_err),
        .idle_cnt       (idle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_mode = 0; m_idle = 0; m_wait = 0;
        m_pend = 0; m_err = 0; m_act = 0; m_a = 4'h0;
    endtask

    task automatic model_step();
        bit act = m_act;
        bit new_err = 0;
        m_act = ((a ^ m_a) != 4'h0) || ext_wake;
        m_a = a;
        if (m_req == 0) begin
            if (!enable) m_idle = 0;
            else if (int'(power_state) != m_mode) begin
                m_idle = 0;
                if (power_state == 2'd3) begin m_req = 3; m_wait = 0; end
                else m_mode = int'(power_state);
            end
            else if (m_mode == 0 && (force_sleep || (!act && m_idle == IS - 1))) begin
                m_req = 1; m_idle = 0; m_wait = 0; m_pend = 0;
            end
            else if (act) begin
                m_idle = 0;
                if (m_mode != 0) begin m_req = 3; m_wait = 0; end
            end
            else if (m_mode == 1 && m_idle == ID - 1) begin
                m_req = 2; m_idle = 0; m_wait = 0; m_pend = 0;
            end
            else if (m_mode != 2) m_idle++;
        end else if (m_req == 3) begin
            if (power_state == 2'd0) begin m_req = 0; m_mode = 0; end
            else if (power_state != 2'd3) begin
                if (m_wait == AT - 1) begin new_err = 1; m_wait = 0; end
                else m_wait++;
            end
        end else begin
            if (int'(power_state) == m_req) begin
                m_mode = m_req; m_req = (m_pend || act) ? 3 : 0; m_pend = 0; m_wait = 0;
            end
            else if (m_wait == AT - 1) begin
                new_err = 1; m_mode = m_req - 1; m_req = 0; m_pend = 0; m_wait = 0;
            end
            else begin m_wait++; m_pend = m_pend | act; end
        end
        m_err = new_err || (m_err && !err_clr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; a = 4'h0; ext_wake = 1'b0; force_sleep = 1'b0;
        err_clr = 1'b0; power_state = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd1, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1, 4'b0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1, 4'b0010};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd3, 4'b0010};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 2'd0, 4'b1000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b1000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd3, 4'b0010};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd2, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 2'd2, 4'b0000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd2, 4'b0010};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 4'b0000};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sleep", sleep_req, 0);
        chk("rst_deep", deep_sleep_req, 0);
        chk("rst_wake", wakeup_req, 0);
        chk("rst_err", req_err, 0);
        chk("rst_idle", idle_cnt, 0);
        rst_n = 1'b1;

        // 1: idle escalation to sleep_req, then SLEEP acknowledge
        n = 0;
        do begin tick(); n++; end while (!sleep_req && n < 200);
        chk("t1_sleep_latency", n, IS);
        repeat (2) tick();
        chk("t1_sleep_held", sleep_req, 1);
        power_state = 2'd1;
        tick();
        chk("t1_sleep_drop", sleep_req, 0);
        chk("t1_state_slp", dut.state_q, ST_SLP);

        // 2: deep sleep, wake through WAKING
        n = 0;
        do begin tick(); n++; end while (!deep_sleep_req && n < 400);
        chk("t2_deep_latency", n, ID);
        power_state = 2'd2;
        tick();
        chk("t2_deep_drop", deep_sleep_req, 0);
        chk("t2_state_deep", dut.state_q, ST_DEEP);
        a = 4'h4;
        repeat (2) tick();
        chk("t2_wake_rise", wakeup_req, 1);
        power_state = 2'd3;
        repeat (8) tick();
        chk("t2_wake_waking", wakeup_req, 1);
        chk("t2_no_err_waking", req_err, 0);
        power_state = 2'd0;
        tick();
        chk("t2_wake_drop", wakeup_req, 0);
        chk("t2_no_err", req_err, 0);
        chk("t2_state_act", dut.state_q, ST_ACT);

        // 3: activity landing on the threshold cycle beats the sleep request
        n = 0;
        while (idle_cnt != 16'd62 && n < 100) begin tick(); n++; end
        chk("t3_reach_62", idle_cnt, 62);
        a = 4'h5;
        tick();
        chk("t3_idle_63", idle_cnt, 63);
        tick();
        chk("t3_idle_cleared", idle_cnt, 0);
        chk("t3_no_sleep", sleep_req, 0);

        // 4: unacknowledged sleep request times out; clear vs same-cycle timeout
        n = 0;
        while (!sleep_req && n < 100) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; end while (sleep_req && n < 100);
        chk("t4_timeout_len", n, AT);
        chk("t4_err_set", req_err, 1);
        chk("t4_state_act", dut.state_q, ST_ACT);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_cleared", req_err, 0);
        force_sleep = 1'b1;
        tick();
        force_sleep = 1'b0;
        repeat (AT - 1) tick();
        chk("t4_sleep_before_to", sleep_req, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_wins_clr", req_err, 1);
        chk("t4_sleep_dropped", sleep_req, 0);

        // 5: wake seen during a sleep request is honoured on acknowledge
        force_sleep = 1'b1;
        tick();
        force_sleep = 1'b0;
        ext_wake = 1'b1;
        tick();
        ext_wake = 1'b0;
        tick();
        chk("t5_sleep_not_aborted", sleep_req, 1);
        power_state = 2'd1;
        tick();
        chk("t5_wake_after_ack", wakeup_req, 1);
        chk("t5_sleep_off", sleep_req, 0);
        power_state = 2'd0;
        tick();
        chk("t5_wake_done", wakeup_req, 0);

        // 6: asynchronous reset in the middle of a deep-sleep request
        power_state = 2'd1;
        tick();
        chk("t6_resync_slp", dut.state_q, ST_SLP);
        n = 0;
        do begin tick(); n++; end while (!deep_sleep_req && n < 400);
        chk("t6_deep_req", deep_sleep_req, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_sleep", sleep_req, 0);
        chk("t6_async_deep", deep_sleep_req, 0);
        chk("t6_async_wake", wakeup_req, 0);
        chk("t6_async_err", req_err, 0);
        chk("t6_async_idle", idle_cnt, 0);
        do_reset();
        force_sleep = 1'b1;
        tick();
        force_sleep = 1'b0;
        chk("t6_force_sleep", sleep_req, 1);

        foreach (tbl[i]) begin
            enable = tbl[i].en; force_sleep = tbl[i].frc; ext_wake = tbl[i].ext; err_clr = tbl[i].clr;
            a = tbl[i].av; power_state = tbl[i].ps;
            tick();
            chk($sformatf("tbl%0d", i), {sleep_req, deep_sleep_req, wakeup_req, req_err}, tbl[i].want);
        end

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            enable = ($urandom_range(0, 19) != 0);
            force_sleep = ($urandom_range(0, 49) == 0);
            ext_wake = ($urandom_range(0, 59) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) a = 4'($urandom);
            if (m_req != 0 && $urandom_range(0, 5) == 0)
                power_state = (m_req == 3) ? ($urandom_range(0, 2) == 0 ? 2'd3 : 2'd0) : 2'(m_req);
            else if ($urandom_range(0, 79) == 0)
                power_state = 2'($urandom_range(0, 3));
            tick();
            chk("rnd_sleep", sleep_req, m_req == 1);
            chk("rnd_deep", deep_sleep_req, m_req == 2);
            chk("rnd_wake", wakeup_req, m_req == 3);
            chk("rnd_err", req_err, m_err);
            chk("rnd_idle", idle_cnt, m_idle);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
